// File: rtl/mlp_pkg.sv
// Shared constants and the sample-to-sign-magnitude helper for the MLP denoiser.
package mlp_pkg;

  localparam int N1      = 98;  // MLP input count (two per window tap)
  localparam int N2      = 16;  // MLP hidden-layer width
  localparam int W_X     = 4;   // magnitude width per tap
  localparam int W_K     = 4;   // MLP weight width
  localparam int W_S     = 8;   // input sample width
  localparam int LAT_MLP = 12;  // MLP input-to-output latency in cycles

  // Returns {pol, mag} for a W_S-bit two's complement sample.
  // The magnitude is taken in W_S+1 bits so the most negative sample is exact,
  // and it is capped at 2^(W_X-1)-1 because the MLP reads mag as signed.
  function automatic logic [W_X:0] sm_quant(input logic [W_S-1:0] sample,
                                            input int unsigned    shift);
    logic [W_S:0] ext_v;
    logic [W_S:0] abs_v;
    logic [W_S:0] shr_v;
    logic [W_S:0] cap_v;
    cap_v = (W_S+1)'((1 << (W_X-1)) - 1);
    ext_v = {sample[W_S-1], sample};
    abs_v = sample[W_S-1] ? ((~ext_v) + (W_S+1)'(1)) : ext_v;
    shr_v = abs_v >> shift;
    return {sample[W_S-1], (shr_v > cap_v) ? cap_v[W_X-1:0] : shr_v[W_X-1:0]};
  endfunction

endpackage

// File: rtl/mlp_frontend_if.sv
// Sample stream handshake between a producer and the MLP front end.
interface mlp_frontend_if #(
  parameter int W_S = 8
);
  logic           s_valid;
  logic           s_ready;
  logic [W_S-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sm_quant_unit.sv
// Combinational conversion of a signed sample into a saturated magnitude and a polarity bit.
module sm_quant_unit #(
  parameter int W_S   = 8,
  parameter int W_X   = 4,
  parameter int SHIFT = 2
) (
  input  logic [W_S-1:0] i_sample,
  output logic [W_X-1:0] o_mag,
  output logic           o_pol
);

  // Largest magnitude the signed consumer can represent.
  localparam logic [W_S:0] CAP = (W_S+1)'((1 << (W_X-1)) - 1);

  logic [W_S:0] w_ext;
  logic [W_S:0] w_abs;
  logic [W_S:0] w_shr;

  // One extra bit keeps |most negative sample| from wrapping.
  assign w_ext = {i_sample[W_S-1], i_sample};
  assign w_abs = i_sample[W_S-1] ? ((~w_ext) + (W_S+1)'(1)) : w_ext;
  assign w_shr = w_abs >> SHIFT;
  assign o_mag = (w_shr > CAP) ? CAP[W_X-1:0] : w_shr[W_X-1:0];
  assign o_pol = i_sample[W_S-1];

endmodule

// File: rtl/mlp_frontend.sv
// Streaming front end: quantises samples into a sliding window that feeds the MLP
// inputs, flags complete windows and tracks the MLP latency with a delay line.
module mlp_frontend
  import mlp_pkg::*;
#(
  parameter int N1     = mlp_pkg::N1,
  parameter int W_X    = mlp_pkg::W_X,
  parameter int W_S    = mlp_pkg::W_S,
  parameter int SHIFT  = 2,
  parameter int STRIDE = 1,
  parameter int LAT    = LAT_MLP
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  mlp_frontend_if.slave                s_if,
  output logic [N1/2-1:0][W_X-1:0]     in_mag,
  output logic [N1/2-1:0]              in_pol,
  output logic                         win_valid,
  output logic                         out_valid
);

  localparam int N_TAP  = N1 / 2;
  localparam int FILL_W = $clog2(N_TAP + 1);
  localparam int SC_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(N_TAP);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N_TAP - 1);
  localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(STRIDE - 1);

  logic [W_X-1:0]    w_mag;
  logic              w_pol;
  logic              w_accept;
  logic              r_ready;
  logic [FILL_W-1:0] r_fill;
  logic [SC_W-1:0]   r_sc;
  logic              r_win;
  logic [LAT-1:0]    r_dly;

  sm_quant_unit #(
    .W_S   (W_S),
    .W_X   (W_X),
    .SHIFT (SHIFT)
  ) u_quant (
    .i_sample (s_if.s_data),
    .o_mag    (w_mag),
    .o_pol    (w_pol)
  );

  // A sample presented together with clear is dropped.
  assign w_accept     = s_if.s_valid && r_ready && !clear;
  assign s_if.s_ready = r_ready;
  assign win_valid    = r_win;
  assign out_valid    = r_dly[LAT-1];

  // Ready comes up on the first edge after reset and never drops: the MLP never stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end

  // Window taps: tap 0 takes the new sample, every other tap takes its younger neighbour.
  for (genvar gi = 0; gi < N_TAP; gi++) begin : g_tap
    logic [W_X-1:0] r_mag;
    logic           r_pol;
    logic [W_X-1:0] w_mag_in;
    logic           w_pol_in;

    if (gi == 0) begin : g_head
      assign w_mag_in = w_mag;
      assign w_pol_in = w_pol;
    end else begin : g_body
      assign w_mag_in = in_mag[gi-1];
      assign w_pol_in = in_pol[gi-1];
    end

    // Shift on accept, flush on clear, hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_mag <= '0;
        r_pol <= 1'b0;
      end else if (clear) begin
        r_mag <= '0;
        r_pol <= 1'b0;
      end else if (w_accept) begin
        r_mag <= w_mag_in;
        r_pol <= w_pol_in;
      end
    end

    assign in_mag[gi] = r_mag;
    assign in_pol[gi] = r_pol;
  end

  // Fill/stride counters; win_valid pulses after the filling accept and on every stride wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fill <= '0;
      r_sc   <= '0;
      r_win  <= 1'b0;
    end else if (clear) begin
      r_fill <= '0;
      r_sc   <= '0;
      r_win  <= 1'b0;
    end else if (w_accept) begin
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + FILL_W'(1);
        r_sc   <= '0;
        r_win  <= (r_fill == FILL_LAST);
      end else if (r_sc == SC_MAX) begin
        r_sc  <= '0;
        r_win <= 1'b1;
      end else begin
        r_sc  <= r_sc + SC_W'(1);
        r_win <= 1'b0;
      end
    end else begin
      r_win <= 1'b0;
    end
  end

  // Delay line matching the MLP latency; clear drops every in-flight result flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_dly <= '0;
    else if (clear) r_dly <= '0;
    else            r_dly <= LAT'({r_dly, r_win});
  end

endmodule
